// File: rtl/fptd_ctrl_pkg.sv
// fptd_ctrl_pkg: shared state encoding and width helpers for the turbo decoder iteration controller
package fptd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ODD    = 3'd2,
        S_EVEN   = 3'd3,
        S_SAMPLE = 3'd4,
        S_CHECK  = 3'd5,
        S_FINISH = 3'd6
    } fptd_ctrl_state_t;

    // Iteration counter must hold MAX_ITER itself, so it never wraps.
    function automatic int itw(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

    // Error count must hold K itself, so the popcount never saturates.
    function automatic int ecw(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/fptd_popcount.sv
// fptd_popcount: combinational count of set per-bit error flags
module fptd_popcount
    import fptd_ctrl_pkg::*;
#(
    parameter int K   = 64,
    parameter int ECW = ecw(K)
) (
    input  logic [K-1:0]   b_error,
    output logic [ECW-1:0] count
);

    // Sum every flag zero-extended to the count width.
    always_comb begin
        count = '0;
        for (int i = 0; i < K; i++)
            count = count + ECW'(b_error[i]);
    end

endmodule

// File: rtl/fptd_iteration_controller.sv
// fptd_iteration_controller: sequences clear/odd/even/sample steps of each decoding iteration for one frame
module fptd_iteration_controller
    import fptd_ctrl_pkg::*;
#(
    parameter int K          = 64,
    parameter int MAX_ITER   = 8,
    parameter int EARLY_TERM = 1,
    parameter int ITW        = itw(MAX_ITER),
    parameter int ECW        = ecw(K)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [K-1:0]   b_error,
    output logic           busy,
    output logic           done,
    output logic           clear_n,
    output logic           pe_en_odd,
    output logic           pe_en_even,
    output logic           est_enable,
    output logic [ITW-1:0] iter_count,
    output logic [ECW-1:0] err_count,
    output logic           early_stop
);

    fptd_ctrl_state_t state, nxt;
    logic [ECW-1:0]   pc;
    logic [ITW-1:0]   iter_next;
    logic             stop_early, last_iter, launch;

    fptd_popcount #(.K(K), .ECW(ECW)) u_popcount (
        .b_error (b_error),
        .count   (pc)
    );

    assign iter_next  = iter_count + 1'b1;
    assign stop_early = (EARLY_TERM != 0) && (pc == '0) && (iter_next < ITW'(MAX_ITER));
    assign last_iter  = iter_next == ITW'(MAX_ITER);
    assign launch     = (state == S_IDLE) && start && !abort;

    // Next-state: fixed four-step iteration loop; abort overrides every transition.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = start ? S_CLEAR : S_IDLE;
            S_CLEAR:  nxt = S_ODD;
            S_ODD:    nxt = S_EVEN;
            S_EVEN:   nxt = S_SAMPLE;
            S_SAMPLE: nxt = S_CHECK;
            S_CHECK:  nxt = (stop_early || last_iter) ? S_FINISH : S_ODD;
            S_FINISH: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (abort)
            nxt = S_IDLE;
    end

    // State and Moore outputs registered from the next state so each output lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            clear_n    <= 1'b1;
            pe_en_odd  <= 1'b0;
            pe_en_even <= 1'b0;
            est_enable <= 1'b0;
        end else begin
            state      <= nxt;
            busy       <= nxt != S_IDLE;
            done       <= nxt == S_FINISH;
            clear_n    <= nxt != S_CLEAR;
            pe_en_odd  <= nxt == S_ODD;
            pe_en_even <= nxt == S_EVEN;
            est_enable <= nxt == S_SAMPLE;
        end
    end

    // Frame statistics: cleared on launch, updated at each iteration check, held across abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count <= '0;
            err_count  <= '0;
            early_stop <= 1'b0;
        end else if (launch) begin
            iter_count <= '0;
            err_count  <= '0;
            early_stop <= 1'b0;
        end else if (state == S_CHECK && !abort) begin
            iter_count <= iter_next;
            err_count  <= pc;
            early_stop <= stop_early;
        end
    end

endmodule

// File: tb/tb_fptd_iteration_controller.sv
// tb_fptd_iteration_controller: directed checks of frame sequencing, early stop, abort and reset
module tb_fptd_iteration_controller;

    localparam int K   = 8;
    localparam int MI  = 4;
    localparam int ITW = 3;
    localparam int ECW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_ne = 1'b0;
    logic abort = 1'b0;
    logic [K-1:0] b_error = '0;

    logic busy, done, clear_n, odd, even, est, early;
    logic [ITW-1:0] iter;
    logic [ECW-1:0] err;
    logic busy_ne, done_ne, clear_n_ne, odd_ne, even_ne, est_ne, early_ne;
    logic [ITW-1:0] iter_ne;
    logic [ECW-1:0] err_ne;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fptd_iteration_controller #(.K(K), .MAX_ITER(MI), .EARLY_TERM(1)) u_et (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b_error(b_error),
        .busy(busy), .done(done), .clear_n(clear_n), .pe_en_odd(odd), .pe_en_even(even),
        .est_enable(est), .iter_count(iter), .err_count(err), .early_stop(early)
    );

    fptd_iteration_controller #(.K(K), .MAX_ITER(MI), .EARLY_TERM(0)) u_ne (
        .clk(clk), .rst_n(rst_n), .start(start_ne), .abort(abort), .b_error(b_error),
        .busy(busy_ne), .done(done_ne), .clear_n(clear_n_ne), .pe_en_odd(odd_ne), .pe_en_even(even_ne),
        .est_enable(est_ne), .iter_count(iter_ne), .err_count(err_ne), .early_stop(early_ne)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Launches a frame and models the estimated-bit cells: set to all-ones on clear,
    // then loaded with the next pattern on each sample strobe so it is valid in CHECK.
    task automatic run_frame(input bit ne, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3, input bit poke,
                             output int done_at, output int n_clr, output int n_odd,
                             output int n_even, output int n_est);
        logic [7:0] pat [4];
        pat = '{p0, p1, p2, p3};
        done_at = -1; n_clr = 0; n_odd = 0; n_even = 0; n_est = 0;
        if (ne) start_ne = 1'b1; else start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            start_ne = 1'b0;
            if (!(ne ? clear_n_ne : clear_n)) begin n_clr++; b_error = '1; end
            if (ne ? odd_ne : odd) n_odd++;
            if (ne ? even_ne : even) n_even++;
            if (ne ? est_ne : est) begin b_error = pat[n_est % 4]; n_est++; end
            if (ne ? done_ne : done) begin done_at = c; break; end
            if (poke && (c == 3 || c == 9 || c == 14)) begin
                if (ne) start_ne = 1'b1; else start = 1'b1;
            end
        end
        start = 1'b0;
        start_ne = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, nc, no, nv, ns, seen, found;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clear_n", 32'(clear_n), 1);
        chk("rst_iter", 32'(iter), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full run, two errors every iteration: no early stop.
        run_frame(0, 8'h03, 8'h03, 8'h03, 8'h03, 0, d, nc, no, nv, ns);
        chk("full_done_at", 32'(d), 18);
        chk("full_clr", 32'(nc), 1);
        chk("full_odd", 32'(no), 4);
        chk("full_even", 32'(nv), 4);
        chk("full_est", 32'(ns), 4);
        chk("full_err", 32'(err), 2);
        chk("full_iter", 32'(iter), 4);
        chk("full_early", 32'(early), 0);
        chk("full_busy_fin", 32'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("full_done_one", 32'(done), 0);
        chk("start_on_done_ign", 32'(busy), 0);
        @(negedge clk);
        chk("start_on_done_idle", 32'(busy), 0);

        // Early stop after third iteration.
        run_frame(0, 8'hFF, 8'h10, 8'h00, 8'h00, 0, d, nc, no, nv, ns);
        chk("early_done_at", 32'(d), 14);
        chk("early_est", 32'(ns), 3);
        chk("early_iter", 32'(iter), 3);
        chk("early_err", 32'(err), 0);
        chk("early_flag", 32'(early), 1);
        @(negedge clk);

        // Early termination disabled, all-zero errors: all iterations run.
        run_frame(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, d, nc, no, nv, ns);
        chk("noet_done_at", 32'(d), 18);
        chk("noet_iter", 32'(iter_ne), 4);
        chk("noet_err", 32'(err_ne), 0);
        chk("noet_early", 32'(early_ne), 0);
        chk("noet_other_idle", 32'(busy), 0);
        @(negedge clk);

        // Zero only on the last allowed iteration: normal completion, early flag cleared.
        run_frame(0, 8'h01, 8'h01, 8'h01, 8'h00, 0, d, nc, no, nv, ns);
        chk("last0_done_at", 32'(d), 18);
        chk("last0_iter", 32'(iter), 4);
        chk("last0_err", 32'(err), 0);
        chk("last0_early", 32'(early), 0);
        @(negedge clk);

        // Start pulses while busy are ignored.
        run_frame(0, 8'h03, 8'h03, 8'h03, 8'h03, 1, d, nc, no, nv, ns);
        chk("busy_start_done_at", 32'(d), 18);
        chk("busy_start_clr", 32'(nc), 1);
        chk("busy_start_est", 32'(ns), 4);
        @(negedge clk);
        chk("busy_start_idle", 32'(busy), 0);

        // Abort during EVEN of iteration 2.
        b_error = 8'h07;
        start = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (even) nv++;
            if (nv == 2) break;
        end
        chk("abort_reach_even2", 32'(nv), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_even", 32'(even), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_iter", 32'(iter), 1);
        chk("abort_err", 32'(err), 3);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | 32'(done) | 32'(busy);
        end
        chk("abort_no_done", 32'(seen), 0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_clear_n", 32'(clear_n), 1);
        chk("sa_iter_held", 32'(iter), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lone_busy", 32'(busy), 1);
        chk("lone_clear_n", 32'(clear_n), 0);
        chk("lone_iter", 32'(iter), 0);
        chk("lone_err", 32'(err), 0);

        // Asynchronous reset in SAMPLE of iteration 2.
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (est) found++;
            if (found == 2) break;
        end
        chk("rst_reach_sample2", 32'(found), 2);
        chk("pre_rst_iter", 32'(iter), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_clear_n", 32'(clear_n), 1);
        chk("arst_odd", 32'(odd), 0);
        chk("arst_even", 32'(even), 0);
        chk("arst_est", 32'(est), 0);
        chk("arst_iter", 32'(iter), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_early", 32'(early), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | 32'(odd) | 32'(even) | 32'(est) | 32'(!clear_n) | 32'(busy) | 32'(done);
        end
        chk("post_rst_quiet", 32'(seen), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fptd_iteration_controller.md
Name: fptd_iteration_controller

Overview:
- Sequences one frame through the fully parallel turbo decoder array under a start/done handshake.
- Each iteration has four steps: clear, odd-PE phase, even-PE phase, then a hard-decision sample strobe to the per-bit estimated-bit/error cells.
- Collects the K per-bit error flags into a registered error count after every iteration.
- Stops at MAX_ITER iterations, or earlier when error-free early termination is enabled.

Parameters:
- K, 64, number of information bits, equal to the number of per-bit error flags.
- MAX_ITER, 8, maximum number of decoding iterations per frame (≥1).
- EARLY_TERM, 1, 1 = stop after the first iteration whose error count is 0.
- ITW, $clog2(MAX_ITER+1), width of the iteration counter.
- ECW, $clog2(K+1), width of the error count.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame start request; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- b_error  in  K  registered per-bit error flags from the estimated-bit cells.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- nClear  out  1  active-low clear to the PE array and estimated-bit cells.
- pe_en_odd  out  1  enable for the odd processing elements.
- pe_en_even  out  1  enable for the even processing elements.
- est_enable  out  1  sample strobe to the estimated-bit cells.
- iter_count  out  ITW  completed iterations in the current or last frame.
- err_count  out  ECW  popcount of b_error latched at the end of each iteration.
- early_stop  out  1  high when the last frame ended on a zero error count before MAX_ITER.

Behaviour:
- Reset (nReset low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, nClear=1, pe_en_odd=0, pe_en_even=0, est_enable=0, iter_count=0, err_count=0, early_stop=0.
- All outputs are registered and Moore-decoded from the state; there is no combinational path from input to output.
- States: IDLE, CLEAR, ODD, EVEN, SAMPLE, CHECK, FINISH.
- IDLE:
  - start=1 moves to CLEAR.
  - iter_count, err_count and early_stop are reset to 0 on that same edge.
- CLEAR:
  - nClear=0 for exactly one cycle, then ODD.
  - The clear forces every b_error to 1, because the cells reset to "error".
- ODD: pe_en_odd=1 for one cycle, then EVEN.
- EVEN: pe_en_even=1 for one cycle, then SAMPLE.
- SAMPLE: est_enable=1 for one cycle, then CHECK.
- CHECK:
  - b_error is valid here, since the cells register on the SAMPLE edge.
  - On the CHECK edge: err_count is loaded with popcount(b_error), and iter_count is incremented.
  - Next state uses the new values:
    - If EARLY_TERM and popcount==0 and new iter_count<MAX_ITER: go to FINISH with early_stop=1.
    - Else if new iter_count==MAX_ITER: go to FINISH with early_stop=0.
    - Else go to ODD. CLEAR is not repeated between iterations; extrinsic state is kept.
- FINISH: done=1 for one cycle, then IDLE.
- Iteration latency: 4 cycles. Frame latency, start to done pulse: 1 + 4·n + 1 cycles for n iterations.
- Zero error count on the last allowed iteration: early_stop=0 (normal completion).
- start while busy: ignored, with no queuing.
- start in the same cycle done is high: ignored, because the state is FINISH, not IDLE.
- abort:
  - Takes priority over every transition; next state is IDLE.
  - Drops all enables; done is not pulsed.
  - iter_count and err_count hold their last values.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and the state stays IDLE.
- Popcount: a pure adder tree over K bits, zero-extended to ECW. It never saturates, because ECW covers the value K.
- iter_count cannot wrap, because ITW covers MAX_ITER.

Decomposition:
- Shared package fptd_ctrl_pkg holds:
  - the state enum fptd_ctrl_state_t;
  - localparam widths helper functions for ITW/ECW.
- One sub-module, fptd_popcount #(K): combinational popcount of b_error. The controller registers its output in CHECK.

Test Plan (K=8, MAX_ITER=4, EARLY_TERM=1 unless noted):
- Reset values: assert nReset low mid-SAMPLE.
  - Outputs go immediately to the reset values listed in Behaviour; state is IDLE.
  - After release, no enable toggles until start.
- Full run with no early stop:
  - Drive b_error=8'b0000_0011 in every CHECK.
  - One nClear low pulse, then 4×(odd, even, est) pulses.
  - err_count=2, iter_count=4, early_stop=0.
  - done pulses exactly 18 cycles after start.
- Early stop:
  - Drive b_error=8'hFF, then 8'h10, then 8'h00 in successive CHECKs.
  - Stops after iteration 3: iter_count=3, err_count=0, early_stop=1, done pulses 14 cycles after start.
- Early termination disabled and zero on the last iteration:
  - EARLY_TERM=0 with b_error=0 on all CHECKs: runs all 4 iterations, early_stop=0.
  - EARLY_TERM=1 with zero only on iteration 4: early_stop=0.
- Abort and start handling:
  - abort in EVEN of iteration 2: next cycle IDLE, busy=0, no done pulse, iter_count=1.
  - start pulses while busy are ignored; the frame length is unchanged.
- start and abort together in IDLE: state stays IDLE. A following lone start begins a frame with iter_count cleared to 0.
